ysyx_22050710_lsu: RTL and testbench
====================================

YSYX_22050710_LSU -- requirements
Module: ysyx_22050710_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255: bus cycles waited for i_mem_ack before the access is abandoned.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_valid  input  1  access request from the execute stage.
REQ-005 SHALL have port o_ready  output  1  LSU idle and able to accept a request.
REQ-006 SHALL have port i_wen  input  1  1 = store, 0 = load.
REQ-007 SHALL have port i_addr  input  64  byte address (the execute-stage ALU result).
REQ-008 SHALL have port i_wdata  input  64  store data, right-aligned.
REQ-009 SHALL have port i_size  input  2  access size: 00 byte, 01 half, 10 word, 11 dword.
REQ-010 SHALL have port o_mem_req  output  1  bus request, held until acknowledged or timed out.
REQ-011 SHALL have port o_mem_we  output  1  bus write enable.
REQ-012 SHALL have port o_mem_addr  output  64  bus address, 8-byte aligned ({addr[63:3],3'b0}).
REQ-013 SHALL have port o_mem_wdata  output  64  lane-shifted store data.
REQ-014 SHALL have port o_mem_wmask  output  8  byte-lane write mask.
REQ-015 SHALL have port i_mem_ack  input  1  bus completion; read data valid in the same cycle.
REQ-016 SHALL have port i_mem_rdata  input  64  bus read data, full aligned dword.
REQ-017 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port o_rdata  output  64  load data right-aligned, zero above i_size; the execute stage sign-extends it.
REQ-019 SHALL have ports o_misalign and o_timeout  output  1 each  error flags, valid only while o_done=1.

Function
REQ-020 SHALL implement FSM IDLE, BUS, DONE; o_ready=1 only in IDLE.
REQ-021 IDLE: on i_valid=1, SHALL latch i_wen, i_addr, i_wdata, i_size; next state is BUS, or DONE with o_misalign=1 if misaligned.
REQ-022 Misaligned SHALL mean addr[0]!=0 for half, addr[1:0]!=0 for word, or addr[2:0]!=0 for dword; a misaligned access SHALL never assert o_mem_req.
REQ-023 BUS: o_mem_req=1 and bus outputs SHALL be stable from latched values; on i_mem_ack=1, SHALL capture o_rdata and go to DONE.
REQ-024 BUS SHALL count cycles from 0; if the count reaches TIMEOUT with i_mem_ack=0, SHALL drop o_mem_req and go to DONE with o_timeout=1.
REQ-025 If i_mem_ack=1 in the same cycle the count reaches TIMEOUT, the ack SHALL win and o_timeout SHALL stay 0.
REQ-026 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE; no back-to-back accept is allowed in DONE.
REQ-027 Latency: accept at cycle 0, o_mem_req at cycle 1, ack at cycle k>=1, o_done at cycle k+1; misaligned o_done at cycle 1.
REQ-028 o_mem_wmask SHALL equal ((1<<(1<<size))-1)<<addr[2:0], truncated to 8 bits, when storing, and 8'h00 for loads.
REQ-029 o_mem_wdata SHALL equal wdata<<(8*addr[2:0]).
REQ-030 o_rdata SHALL equal (i_mem_rdata>>(8*addr[2:0])) masked to 8/16/32/64 bits, held until the next ack; on timeout or misalign it SHALL be 0.
REQ-031 i_valid outside IDLE SHALL be ignored; i_mem_ack outside BUS SHALL be ignored.

Reset
REQ-032 With i_rst=1 at a clock edge, SHALL enter IDLE with o_ready=1 and o_mem_req, o_mem_we, o_done, o_misalign, o_timeout=0, o_mem_wmask=0, o_rdata=0, and counter=0.
REQ-033 Reset asserted in BUS or DONE SHALL abort the access: no o_done pulse, and o_mem_req low the following cycle.

Verification
REQ-034 Load: size=10, addr=0x80000004, rdata=0x11223344_55667788, ack on 3rd BUS cycle -> o_mem_addr=0x80000000, o_rdata=0x11223344, o_done exactly once at accept+4.
REQ-035 Store: size=01, addr=0x80000006, wdata=0xBEEF -> wmask=8'hC0, o_mem_wdata=0xBEEF0000_00000000, o_mem_we=1.
REQ-036 Misaligned: size=11, addr=0x80000004 -> no o_mem_req, o_done and o_misalign=1 at cycle 1.
REQ-037 Timeout: TIMEOUT=4, no ack -> o_mem_req high 4 cycles, then o_done with o_timeout=1; ack on the 4th cycle -> o_timeout=0.
REQ-038 Reset during BUS -> o_mem_req=0 and o_ready=1 the next cycle, no o_done; i_valid during DONE is ignored.

Source files
------------

// File: rtl/ysyx_22050710_lsu_if.sv
// ----------------------------------------------------------------------------
// ysyx_22050710_lsu_if
// Bundles everything that connects the load/store unit to its two neighbours:
//   - execute-stage request side: i_valid, o_ready, i_wen, i_addr, i_wdata,
//     i_size, and the completion side o_done, o_rdata, o_misalign, o_timeout
//   - memory bus side: o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
//     o_mem_wmask, i_mem_ack, i_mem_rdata
// Signal names carry the LSU's point of view (i_ = into the LSU, o_ = out of
// it), so the same name is used on both sides of the connection.
// Modports:
//   slave  - the LSU itself
//   master - the environment around it (execute stage plus memory)
// ----------------------------------------------------------------------------
interface ysyx_22050710_lsu_if;

  // execute-stage request
  logic        i_valid;
  logic        o_ready;
  logic        i_wen;
  logic [63:0] i_addr;
  logic [63:0] i_wdata;
  logic [1:0]  i_size;

  // memory bus
  logic        o_mem_req;
  logic        o_mem_we;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_ack;
  logic [63:0] i_mem_rdata;

  // completion back to the execute stage
  logic        o_done;
  logic [63:0] o_rdata;
  logic        o_misalign;
  logic        o_timeout;

  modport slave (
    input  i_valid, i_wen, i_addr, i_wdata, i_size,
    input  i_mem_ack, i_mem_rdata,
    output o_ready,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    output o_done, o_rdata, o_misalign, o_timeout
  );

  modport master (
    output i_valid, i_wen, i_addr, i_wdata, i_size,
    output i_mem_ack, i_mem_rdata,
    input  o_ready,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    input  o_done, o_rdata, o_misalign, o_timeout
  );

endinterface

// File: rtl/ysyx_22050710_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_22050710_lsu
// Load/store unit between the execute stage and a simple req/ack memory bus.
// One access at a time: IDLE accepts a request, BUS holds the aligned bus
// request until ack or timeout, DONE emits a one-cycle completion pulse.
// Misaligned accesses skip the bus and complete immediately with o_misalign.
//
// Parameters:
//   TIMEOUT - bus cycles waited for i_mem_ack before the access is abandoned
// Ports:
//   i_clk - clock, all state changes on the rising edge
//   i_rst - synchronous active-high reset
//   lsu   - ysyx_22050710_lsu_if.slave (request, bus and completion signals)
// All outputs are registered.
// ----------------------------------------------------------------------------
module ysyx_22050710_lsu #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  ysyx_22050710_lsu_if.slave         lsu
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // helpers
  // --------------------------------------------------------------------------

  // True when the byte offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [2:0] off);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = (off[0] != 1'b0);
      2'b10:   bad = (off[1:0] != 2'b00);
      2'b11:   bad = (off != 3'b000);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-lane write mask for an access of the given size at the given offset.
  // Bits pushed past lane 7 are dropped; aligned accesses never do that.
  function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                           input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      2'b11:   base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Keep only the low 8/16/32/64 bits of a load result.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      2'b00:   m = 64'h0000_0000_0000_00FF;
      2'b01:   m = 64'h0000_0000_0000_FFFF;
      2'b10:   m = 64'h0000_0000_FFFF_FFFF;
      2'b11:   m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = 64'h0000_0000_0000_0000;
    endcase
    return m;
  endfunction

  // Move right-aligned store data up to its byte lane.
  function automatic logic [63:0] lane_data(input logic [63:0] data,
                                            input logic [2:0]  off);
    return data << {off, 3'b000};
  endfunction

  // Bring the addressed bytes of a full bus dword down to bit 0.
  function automatic logic [63:0] load_align(input logic [63:0] data,
                                             input logic [2:0]  off,
                                             input logic [1:0]  size);
    return (data >> {off, 3'b000}) & size_mask(size);
  endfunction

  // --------------------------------------------------------------------------
  // state
  // --------------------------------------------------------------------------
  state_t      state_r;
  logic [7:0]  cnt_r;     // BUS cycles already spent waiting for ack
  logic [2:0]  off_r;     // latched byte offset, needed to align read data
  logic [1:0]  size_r;    // latched access size, needed to mask read data

  logic        req_misalign_s;
  logic        bus_expire_s;
  logic [63:0] load_data_s;

  // Decode the incoming request and the bus-wait limit.
  always_comb begin
    req_misalign_s = misaligned(lsu.i_size, lsu.i_addr[2:0]);
    // 9-bit compare: the current BUS cycle is number cnt_r+1; when that
    // reaches TIMEOUT without ack the access is abandoned at this edge.
    if (({1'b0, cnt_r} + 9'd1) >= {1'b0, TIMEOUT}) begin
      bus_expire_s = 1'b1;
    end else begin
      bus_expire_s = 1'b0;
    end
    load_data_s = load_align(lsu.i_mem_rdata, off_r, size_r);
  end

  // Access FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 8'd0;
      off_r           <= 3'd0;
      size_r          <= 2'd0;
      lsu.o_ready     <= 1'b1;
      lsu.o_mem_req   <= 1'b0;
      lsu.o_mem_we    <= 1'b0;
      lsu.o_mem_addr  <= 64'd0;
      lsu.o_mem_wdata <= 64'd0;
      lsu.o_mem_wmask <= 8'h00;
      lsu.o_done      <= 1'b0;
      lsu.o_rdata     <= 64'd0;
      lsu.o_misalign  <= 1'b0;
      lsu.o_timeout   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          lsu.o_done     <= 1'b0;
          lsu.o_misalign <= 1'b0;
          lsu.o_timeout  <= 1'b0;
          if (lsu.i_valid) begin
            off_r           <= lsu.i_addr[2:0];
            size_r          <= lsu.i_size;
            cnt_r           <= 8'd0;
            lsu.o_ready     <= 1'b0;
            lsu.o_mem_addr  <= {lsu.i_addr[63:3], 3'b000};
            lsu.o_mem_wdata <= lane_data(lsu.i_wdata, lsu.i_addr[2:0]);
            if (req_misalign_s) begin
              // Never reaches the bus: complete straight away with the flag.
              state_r         <= ST_DONE;
              lsu.o_mem_req   <= 1'b0;
              lsu.o_mem_we    <= 1'b0;
              lsu.o_mem_wmask <= 8'h00;
              lsu.o_done      <= 1'b1;
              lsu.o_misalign  <= 1'b1;
              lsu.o_rdata     <= 64'd0;
            end else begin
              state_r         <= ST_BUS;
              lsu.o_mem_req   <= 1'b1;
              lsu.o_mem_we    <= lsu.i_wen;
              lsu.o_mem_wmask <= lsu.i_wen ?
                                 lane_mask(lsu.i_size, lsu.i_addr[2:0]) : 8'h00;
            end
          end else begin
            lsu.o_ready <= 1'b1;
          end
        end

        ST_BUS: begin
          // Ack is checked first so it wins over an expiring count.
          if (lsu.i_mem_ack) begin
            state_r         <= ST_DONE;
            cnt_r           <= 8'd0;
            lsu.o_mem_req   <= 1'b0;
            lsu.o_mem_we    <= 1'b0;
            lsu.o_mem_wmask <= 8'h00;
            lsu.o_done      <= 1'b1;
            lsu.o_rdata     <= load_data_s;
          end else if (bus_expire_s) begin
            state_r         <= ST_DONE;
            cnt_r           <= 8'd0;
            lsu.o_mem_req   <= 1'b0;
            lsu.o_mem_we    <= 1'b0;
            lsu.o_mem_wmask <= 8'h00;
            lsu.o_done      <= 1'b1;
            lsu.o_timeout   <= 1'b1;
            lsu.o_rdata     <= 64'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end

        ST_DONE: begin
          // Single pulse; a request seen here is dropped, not queued.
          state_r        <= ST_IDLE;
          lsu.o_ready    <= 1'b1;
          lsu.o_done     <= 1'b0;
          lsu.o_misalign <= 1'b0;
          lsu.o_timeout  <= 1'b0;
        end

        default: begin
          state_r         <= ST_IDLE;
          cnt_r           <= 8'd0;
          lsu.o_ready     <= 1'b1;
          lsu.o_mem_req   <= 1'b0;
          lsu.o_mem_we    <= 1'b0;
          lsu.o_mem_wmask <= 8'h00;
          lsu.o_done      <= 1'b0;
          lsu.o_misalign  <= 1'b0;
          lsu.o_timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_lsu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050710_lsu
// Directed and randomized accesses against ysyx_22050710_lsu (TIMEOUT=4).
// Expected values come from a small arithmetic model of the access rules.
// ----------------------------------------------------------------------------
module tb_ysyx_22050710_lsu;

  localparam logic [7:0] TO   = 8'd4;
  localparam int         TO_I = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  ysyx_22050710_lsu_if lsu_bus ();

  ysyx_22050710_lsu #(.TIMEOUT(TO)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .lsu   (lsu_bus)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  function automatic logic m_misalign(input logic [63:0] addr, input logic [1:0] sz);
    return (addr % (64'd1 << sz)) != 64'd0;
  endfunction

  function automatic logic [7:0] m_wmask(input logic [63:0] addr, input logic [1:0] sz);
    logic [15:0] t;
    t = ((16'd1 << (1 << sz)) - 16'd1) << addr[2:0];
    return t[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] addr, input logic [63:0] wd);
    return wd << (8 * addr[2:0]);
  endfunction

  function automatic logic [63:0] m_rdata(input logic [63:0] addr, input logic [1:0] sz,
                                          input logic [63:0] rd);
    logic [127:0] lim;
    logic [127:0] v;
    lim = (128'd1 << (8 << sz)) - 128'd1;
    v   = ({64'd0, rd} >> (8 * addr[2:0])) & lim;
    return v[63:0];
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // One full access starting at a negedge in IDLE. ack_at = BUS cycle (1..)
  // on which ack is raised; anything outside 1..TO_I means no ack.
  // poke = raise i_valid during the DONE cycle, which must be ignored.
  task automatic run_access(input logic wen, input logic [63:0] addr,
                            input logic [63:0] wd, input logic [1:0] sz,
                            input int ack_at, input logic [63:0] rd,
                            input logic poke);
    logic        mis;
    logic        exp_to;
    mis    = m_misalign(addr, sz);
    exp_to = !(ack_at >= 1 && ack_at <= TO_I);
    chk("ready_idle", {63'd0, lsu_bus.o_ready}, 64'd1);
    lsu_bus.i_valid = 1'b1;
    lsu_bus.i_wen   = wen;
    lsu_bus.i_addr  = addr;
    lsu_bus.i_wdata = wd;
    lsu_bus.i_size  = sz;
    tick();
    lsu_bus.i_valid = 1'b0;
    lsu_bus.i_addr  = {$urandom(), $urandom()};
    lsu_bus.i_wdata = {$urandom(), $urandom()};
    chk("ready_busy", {63'd0, lsu_bus.o_ready}, 64'd0);
    if (mis) begin
      chk("mis_req",   {63'd0, lsu_bus.o_mem_req},  64'd0);
      chk("mis_done",  {63'd0, lsu_bus.o_done},     64'd1);
      chk("mis_flag",  {63'd0, lsu_bus.o_misalign}, 64'd1);
      chk("mis_to",    {63'd0, lsu_bus.o_timeout},  64'd0);
      chk("mis_rdata", lsu_bus.o_rdata,             64'd0);
    end else begin
      chk("bus_addr",  lsu_bus.o_mem_addr, {addr[63:3], 3'b000});
      chk("bus_we",    {63'd0, lsu_bus.o_mem_we}, {63'd0, wen});
      chk("bus_wmask", {56'd0, lsu_bus.o_mem_wmask},
          wen ? {56'd0, m_wmask(addr, sz)} : 64'd0);
      chk("bus_wdata", lsu_bus.o_mem_wdata, m_wdata(addr, wd));
      for (int j = 1; j <= TO_I; j++) begin
        chk("req_hold",  {63'd0, lsu_bus.o_mem_req}, 64'd1);
        chk("addr_hold", lsu_bus.o_mem_addr, {addr[63:3], 3'b000});
        chk("no_done",   {63'd0, lsu_bus.o_done}, 64'd0);
        lsu_bus.i_mem_ack   = (j == ack_at);
        lsu_bus.i_mem_rdata = (j == ack_at) ? rd : {$urandom(), $urandom()};
        tick();
        lsu_bus.i_mem_ack   = 1'b0;
        lsu_bus.i_mem_rdata = {$urandom(), $urandom()};
        if (j == ack_at) break;
      end
      chk("done",       {63'd0, lsu_bus.o_done},     64'd1);
      chk("done_req",   {63'd0, lsu_bus.o_mem_req},  64'd0);
      chk("done_to",    {63'd0, lsu_bus.o_timeout},  {63'd0, exp_to});
      chk("done_mis",   {63'd0, lsu_bus.o_misalign}, 64'd0);
      chk("done_rdata", lsu_bus.o_rdata, exp_to ? 64'd0 : m_rdata(addr, sz, rd));
    end
    if (poke) begin
      lsu_bus.i_valid = 1'b1;
      lsu_bus.i_addr  = 64'h0000_0000_8000_0000;
      lsu_bus.i_size  = 2'b00;
    end
    tick();
    lsu_bus.i_valid = 1'b0;
    chk("after_done",  {63'd0, lsu_bus.o_done},    64'd0);
    chk("after_ready", {63'd0, lsu_bus.o_ready},   64'd1);
    chk("after_req",   {63'd0, lsu_bus.o_mem_req}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    lsu_bus.i_valid     = 1'b0;
    lsu_bus.i_wen       = 1'b0;
    lsu_bus.i_addr      = 64'd0;
    lsu_bus.i_wdata     = 64'd0;
    lsu_bus.i_size      = 2'b00;
    lsu_bus.i_mem_ack   = 1'b0;
    lsu_bus.i_mem_rdata = 64'd0;

    // reset state
    tick();
    tick();
    chk("rst_ready",  {63'd0, lsu_bus.o_ready},     64'd1);
    chk("rst_req",    {63'd0, lsu_bus.o_mem_req},   64'd0);
    chk("rst_we",     {63'd0, lsu_bus.o_mem_we},    64'd0);
    chk("rst_done",   {63'd0, lsu_bus.o_done},      64'd0);
    chk("rst_mis",    {63'd0, lsu_bus.o_misalign},  64'd0);
    chk("rst_to",     {63'd0, lsu_bus.o_timeout},   64'd0);
    chk("rst_wmask",  {56'd0, lsu_bus.o_mem_wmask}, 64'd0);
    chk("rst_rdata",  lsu_bus.o_rdata,              64'd0);
    i_rst = 1'b0;
    tick();

    // ack while idle is ignored
    lsu_bus.i_mem_ack = 1'b1;
    tick();
    tick();
    lsu_bus.i_mem_ack = 1'b0;
    chk("idle_ack_done",  {63'd0, lsu_bus.o_done},  64'd0);
    chk("idle_ack_ready", {63'd0, lsu_bus.o_ready}, 64'd1);

    // word load, ack on third BUS cycle -> done at accept+4
    run_access(1'b0, 64'h0000_0000_8000_0004, 64'd0, 2'b10, 3,
               64'h1122_3344_5566_7788, 1'b0);
    chk("load_word_value", lsu_bus.o_rdata, 64'h0000_0000_1122_3344);

    // half store into the top lanes
    run_access(1'b1, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_BEEF, 2'b01, 1,
               64'hA5A5_A5A5_5A5A_5A5A, 1'b0);

    // misaligned dword, with a request poked into DONE
    run_access(1'b0, 64'h0000_0000_8000_0004, 64'd0, 2'b11, 1, 64'd0, 1'b1);

    // timeout with no ack, then ack on the last allowed cycle
    run_access(1'b0, 64'h0000_0000_8000_0010, 64'd0, 2'b11, 0,
               64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    run_access(1'b0, 64'h0000_0000_8000_0011, 64'd0, 2'b00, TO_I,
               64'hDEAD_BEEF_CAFE_F00D, 1'b1);

    // reset while in BUS aborts the access
    lsu_bus.i_valid = 1'b1;
    lsu_bus.i_wen   = 1'b0;
    lsu_bus.i_addr  = 64'h0000_0000_8000_0020;
    lsu_bus.i_size  = 2'b11;
    tick();
    lsu_bus.i_valid = 1'b0;
    chk("rb_req", {63'd0, lsu_bus.o_mem_req}, 64'd1);
    i_rst = 1'b1;
    tick();
    chk("rb_req_low", {63'd0, lsu_bus.o_mem_req}, 64'd0);
    chk("rb_ready",   {63'd0, lsu_bus.o_ready},   64'd1);
    chk("rb_done",    {63'd0, lsu_bus.o_done},    64'd0);
    chk("rb_rdata",   lsu_bus.o_rdata,            64'd0);
    i_rst = 1'b0;
    tick();
    chk("rb_no_done", {63'd0, lsu_bus.o_done},  64'd0);
    chk("rb_ready2",  {63'd0, lsu_bus.o_ready}, 64'd1);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic [63:0] a;
      logic [63:0] w;
      logic [63:0] r;
      logic [1:0]  s;
      logic        we;
      int          k;
      a  = {$urandom(), $urandom()};
      w  = {$urandom(), $urandom()};
      r  = {$urandom(), $urandom()};
      s  = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      k  = $urandom_range(1, TO_I + 1);
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
      run_access(we, a, w, s, k, r, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
